sram_arbiter: RTL and testbench

- Two-requester arbiter in front of the external SRAM controller (`ext_sram` request interface: stb/ack/rw/addr/dtw/dtr).
- Port D is the data load/store unit and has priority. Port I is instruction fetch; it is protected from starvation by a grant counter.
- Each port's one-cycle strobe is captured into a pending slot, issued downstream as a one-cycle `m_stb`, and completed with a one-cycle `ack` and read data.
- A watchdog aborts transactions the memory never acknowledges.

---
 rtl/hs32_sram_pkg.sv | 22 ++
 rtl/sram_arb_slot.sv | 72 +++++++
 rtl/sram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_sram_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
package hs32_sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } arb_state_e;

   localparam logic PORT_D = 1'b0;
   localparam logic PORT_I = 1'b1;

   localparam int unsigned REQ_W = 1 + 32 + 32;

   typedef struct packed {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] dtw;
   } req_t;

endpackage

// File: rtl/sram_arb_slot.sv
// One requester slot: captures a strobed request, holds busy until the
// arbiter completes it, and registers the ack/err pulse and read data.
module sram_arb_slot
   import hs32_sram_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stb,
   input  logic        rw,
   input  logic [31:0] addr,
   input  logic [31:0] dtw,
   input  logic        done,
   input  logic        abort,
   input  logic        rd_load,
   input  logic [31:0] rd_data,
   output req_t        req,
   output logic        busy,
   output logic        ack,
   output logic        err,
   output logic [31:0] dtr
);

   req_t        req_q, req_d;
   logic        busy_q, busy_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] dtr_q, dtr_d;

   // Completion wins over capture; a strobe while busy is dropped.
   always_comb begin
      req_d  = req_q;
      busy_d = busy_q;
      ack_d  = 1'b0;
      err_d  = 1'b0;
      dtr_d  = dtr_q;
      if (done) begin
         busy_d = 1'b0;
         ack_d  = 1'b1;
         err_d  = abort;
         if (rd_load) begin
            dtr_d = rd_data;
         end
      end else if (stb && !busy_q) begin
         busy_d = 1'b1;
         req_d  = '{rw: rw, addr: addr, dtw: dtw};
      end
   end

   // Slot state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q  <= '0;
         busy_q <= 1'b0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         dtr_q  <= '0;
      end else begin
         req_q  <= req_d;
         busy_q <= busy_d;
         ack_q  <= ack_d;
         err_q  <= err_d;
         dtr_q  <= dtr_d;
      end
   end

   assign req  = req_q;
   assign busy = busy_q;
   assign ack  = ack_q;
   assign err  = err_q;
   assign dtr  = dtr_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter (D priority, I anti-starvation) in front of the
// external SRAM request interface, with a no-ack watchdog.
module sram_arbiter
   import hs32_sram_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT_CYC  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        d_stb,
   input  logic        d_rw,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_dtw,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_dtr,
   output logic        d_busy,
   input  logic        i_stb,
   input  logic        i_rw,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_dtw,
   output logic        i_ack,
   output logic        i_err,
   output logic [31:0] i_dtr,
   output logic        i_busy,
   output logic        m_stb,
   output logic        m_rw,
   output logic [31:0] m_addr,
   output logic [31:0] m_dtw,
   input  logic        m_ack,
   input  logic [31:0] m_dtr
);

   arb_state_e  state_q, state_d;
   logic        grant_q, grant_d;
   logic        m_stb_q, m_stb_d;
   logic        m_rw_q, m_rw_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_dtw_q, m_dtw_d;
   logic [31:0] wd_q, wd_d;
   logic [31:0] starve_q, starve_d;

   req_t        d_req, i_req, win_req;
   logic        win_i;
   logic        done, abort, rd_load;
   logic        d_done, i_done;

   // Next-state, grant selection, starve and watchdog counters.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      m_stb_d  = 1'b0;
      m_rw_d   = m_rw_q;
      m_addr_d = m_addr_q;
      m_dtw_d  = m_dtw_q;
      wd_d     = wd_q;
      starve_d = starve_q;
      done     = 1'b0;
      abort    = 1'b0;
      rd_load  = 1'b0;
      win_i    = !d_busy ||
                 (i_busy && (STARVE_LIMIT != 0) && (starve_q == STARVE_LIMIT));
      win_req  = win_i ? i_req : d_req;
      unique case (state_q)
         ST_IDLE: begin
            if (d_busy || i_busy) begin
               grant_d  = win_i ? PORT_I : PORT_D;
               m_rw_d   = win_req.rw;
               m_addr_d = win_req.addr;
               m_dtw_d  = win_req.dtw;
               m_stb_d  = 1'b1;
               state_d  = ST_ISSUE;
               if (win_i) begin
                  starve_d = '0;
               end else if (i_busy && (starve_q != STARVE_LIMIT)) begin
                  starve_d = starve_q + 32'd1;
               end
            end
         end
         ST_ISSUE: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (m_ack) begin
               done    = 1'b1;
               rd_load = !m_rw_q;
               state_d = ST_RESP;
            end else if ((TIMEOUT_CYC != 0) && (wd_q == TIMEOUT_CYC - 1)) begin
               done    = 1'b1;
               abort   = 1'b1;
               state_d = ST_RESP;
            end else begin
               wd_d = wd_q + 32'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (!i_busy) begin
         starve_d = '0;
      end
   end

   // Arbiter and downstream request registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         grant_q  <= PORT_D;
         m_stb_q  <= 1'b0;
         m_rw_q   <= 1'b0;
         m_addr_q <= '0;
         m_dtw_q  <= '0;
         wd_q     <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         m_stb_q  <= m_stb_d;
         m_rw_q   <= m_rw_d;
         m_addr_q <= m_addr_d;
         m_dtw_q  <= m_dtw_d;
         wd_q     <= wd_d;
         starve_q <= starve_d;
      end
   end

   assign d_done = done && (grant_q == PORT_D);
   assign i_done = done && (grant_q == PORT_I);

   assign m_stb  = m_stb_q;
   assign m_rw   = m_rw_q;
   assign m_addr = m_addr_q;
   assign m_dtw  = m_dtw_q;

   sram_arb_slot u_slot_d (
      .clk     (clk),
      .reset   (reset),
      .stb     (d_stb),
      .rw      (d_rw),
      .addr    (d_addr),
      .dtw     (d_dtw),
      .done    (d_done),
      .abort   (abort),
      .rd_load (rd_load),
      .rd_data (m_dtr),
      .req     (d_req),
      .busy    (d_busy),
      .ack     (d_ack),
      .err     (d_err),
      .dtr     (d_dtr)
   );

   sram_arb_slot u_slot_i (
      .clk     (clk),
      .reset   (reset),
      .stb     (i_stb),
      .rw      (i_rw),
      .addr    (i_addr),
      .dtw     (i_dtw),
      .done    (i_done),
      .abort   (abort),
      .rd_load (rd_load),
      .rd_data (m_dtr),
      .req     (i_req),
      .busy    (i_busy),
      .ack     (i_ack),
      .err     (i_err),
      .dtr     (i_dtr)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level reference model
// driven by directed scenarios followed by a randomized run.
module tb_sram_arbiter;

   localparam int unsigned LIM = 4;
   localparam int unsigned TMO = 8;

   logic        clk, reset;
   logic        d_stb, d_rw, d_ack, d_err, d_busy;
   logic [31:0] d_addr, d_dtw, d_dtr;
   logic        i_stb, i_rw, i_ack, i_err, i_busy;
   logic [31:0] i_addr, i_dtw, i_dtr;
   logic        m_stb, m_rw, m_ack;
   logic [31:0] m_addr, m_dtw, m_dtr;

   sram_arbiter #(.STARVE_LIMIT(LIM), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset),
      .d_stb(d_stb), .d_rw(d_rw), .d_addr(d_addr), .d_dtw(d_dtw),
      .d_ack(d_ack), .d_err(d_err), .d_dtr(d_dtr), .d_busy(d_busy),
      .i_stb(i_stb), .i_rw(i_rw), .i_addr(i_addr), .i_dtw(i_dtw),
      .i_ack(i_ack), .i_err(i_err), .i_dtr(i_dtr), .i_busy(i_busy),
      .m_stb(m_stb), .m_rw(m_rw), .m_addr(m_addr), .m_dtw(m_dtw),
      .m_ack(m_ack), .m_dtr(m_dtr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // reference model: per-port pending requests and transaction bookkeeping
   bit          pend[2], prev_p[2];
   bit          prev_idle;
   logic        rw_m[2];
   logic [31:0] addr_m[2], dtw_m[2], dtr_m[2];
   int unsigned starve_m;
   bit          txn;
   int          cur_port, cur_delay, cnt;
   int          cyc, mstb_cyc, mack_cyc, exp_ack_cyc, dack_cyc;
   logic [31:0] rdata;
   int          dack_cnt, ierr_cnt;
   int          grants[$];

   // scenario knobs
   int          delay_cfg;
   bit          delay_rand, stray_en, auto_d, auto_i, rd_fixed;
   logic [31:0] rd_fixed_val;
   bit          req_en[2];
   logic        req_rw[2];
   logic [31:0] req_addr[2], req_dtw[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input int p, input logic rw, input logic [31:0] a, input logic [31:0] w);
      req_en[p]   = 1'b1;
      req_rw[p]   = rw;
      req_addr[p] = a;
      req_dtw[p]  = w;
   endtask

   task automatic model_reset();
      pend      = '{0, 0};
      prev_p    = '{0, 0};
      prev_idle = 1'b1;
      dtr_m     = '{32'h0, 32'h0};
      starve_m  = 0;
      txn       = 1'b0;
      exp_ack_cyc = -1;
      m_ack     = 1'b0;
      req_en    = '{0, 0};
   endtask

   // One clock cycle: check outputs at the negedge, advance the model,
   // play the downstream responder, then drive new strobes.
   task automatic step();
      bit exp_mstb, exp_ack, abort, cur_idle, win_i;
      @(negedge clk);
      cyc++;
      exp_mstb = prev_idle && (prev_p[0] || prev_p[1]);
      chk("m_stb", m_stb, exp_mstb);
      if (exp_mstb) begin
         win_i = !prev_p[0] || (prev_p[1] && LIM != 0 && starve_m == LIM);
         cur_port = win_i ? 1 : 0;
         if (win_i) starve_m = 0;
         else if (prev_p[1]) starve_m = (starve_m < LIM) ? starve_m + 1 : LIM;
         else starve_m = 0;
         grants.push_back(cur_port);
         txn = 1'b1;
         mstb_cyc = cyc;
         if (delay_rand) cur_delay = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 7));
         else cur_delay = delay_cfg;
         cnt = cur_delay;
         exp_ack_cyc = (cur_delay < 0) ? cyc + int'(TMO) + 1 : -1;
      end
      if (txn) begin
         chk("m_rw", m_rw, rw_m[cur_port]);
         chk("m_addr", m_addr, addr_m[cur_port]);
         chk("m_dtw", m_dtw, dtw_m[cur_port]);
      end
      exp_ack = txn && (cyc == exp_ack_cyc);
      abort   = exp_ack && (cur_delay < 0);
      if (exp_ack) begin
         if (!abort && !rw_m[cur_port]) dtr_m[cur_port] = rdata;
         pend[cur_port] = 1'b0;
      end
      chk("d_ack", d_ack, exp_ack && cur_port == 0);
      chk("i_ack", i_ack, exp_ack && cur_port == 1);
      chk("d_err", d_err, abort && cur_port == 0);
      chk("i_err", i_err, abort && cur_port == 1);
      chk("d_dtr", d_dtr, dtr_m[0]);
      chk("i_dtr", i_dtr, dtr_m[1]);
      chk("d_busy", d_busy, pend[0]);
      chk("i_busy", i_busy, pend[1]);
      if (d_ack === 1'b1) begin
         dack_cnt++;
         dack_cyc = cyc;
      end
      if (i_err === 1'b1) ierr_cnt++;
      if (exp_ack && auto_d && cur_port == 0) req(0, 1'($urandom), $urandom, $urandom);
      if (exp_ack && auto_i && cur_port == 1) req(1, 1'b0, $urandom, $urandom);
      cur_idle = !txn;
      if (exp_ack) txn = 1'b0;
      prev_p    = pend;
      prev_idle = cur_idle;
      m_ack = 1'b0;
      m_dtr = $urandom;
      if (txn && !exp_mstb && cur_delay > 0) begin
         cnt--;
         if (cnt == 0) begin
            m_ack = 1'b1;
            if (rd_fixed) m_dtr = rd_fixed_val;
            rdata = m_dtr;
            mack_cyc = cyc;
            exp_ack_cyc = cyc + 1;
         end
      end else if (stray_en && (cur_idle || exp_mstb) && $urandom_range(0, 3) == 0) begin
         m_ack = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
         if (req_en[p] && !pend[p]) begin
            pend[p]   = 1'b1;
            rw_m[p]   = req_rw[p];
            addr_m[p] = req_addr[p];
            dtw_m[p]  = req_dtw[p];
         end
      end
      d_stb  = req_en[0];
      d_rw   = req_en[0] ? req_rw[0] : 1'($urandom);
      d_addr = req_en[0] ? req_addr[0] : $urandom;
      d_dtw  = req_en[0] ? req_dtw[0] : $urandom;
      i_stb  = req_en[1];
      i_rw   = req_en[1] ? req_rw[1] : 1'($urandom);
      i_addr = req_en[1] ? req_addr[1] : $urandom;
      i_dtw  = req_en[1] ? req_dtw[1] : $urandom;
      req_en = '{0, 0};
   endtask

   initial begin
      int stb_cyc, base, exp_g[10];
      exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      reset = 1'b1;
      d_stb = 1'b0; d_rw = 1'b0; d_addr = '0; d_dtw = '0;
      i_stb = 1'b0; i_rw = 1'b0; i_addr = '0; i_dtw = '0;
      m_dtr = '0;
      cyc = 0; dack_cnt = 0; ierr_cnt = 0; dack_cyc = -1; mack_cyc = -1;
      delay_cfg = 5; delay_rand = 0; stray_en = 0; auto_d = 0; auto_i = 0;
      rd_fixed = 1'b1; rd_fixed_val = 32'hDEADBEEF;
      model_reset();

      // reset state
      repeat (2) step();
      chk("rst_m_addr", m_addr, 32'h0);
      chk("rst_m_dtw", m_dtw, 32'h0);
      chk("rst_m_rw", m_rw, 1'b0);
      reset = 1'b0;

      // single read with a 5-cycle responder
      req(0, 1'b0, 32'h00001234, 32'h0);
      stb_cyc = cyc + 1;
      repeat (12) step();
      chk("single_mstb_lat", mstb_cyc, stb_cyc + 2);
      chk("single_ack_lat", dack_cyc, mack_cyc + 1);
      chk("single_dtr", d_dtr, 32'hDEADBEEF);
      chk("single_busy", d_busy, 1'b0);

      // simultaneous D write and I read
      grants.delete();
      delay_cfg = 3; rd_fixed_val = 32'h5555AAAA;
      req(0, 1'b1, 32'h00000010, 32'hCAFEF00D);
      req(1, 1'b0, 32'h00000020, 32'h0);
      repeat (20) step();
      chk("simul_count", grants.size(), 2);
      chk("simul_first", grants.size() > 0 ? grants[0] : 9, 0);
      chk("simul_second", grants.size() > 1 ? grants[1] : 9, 1);
      chk("simul_i_dtr", i_dtr, 32'h5555AAAA);
      chk("simul_d_dtr", d_dtr, 32'hDEADBEEF);

      // timeout then a normal follow-up request
      delay_cfg = -1;
      base = ierr_cnt;
      req(1, 1'b0, 32'h00000300, 32'h0);
      repeat (14) step();
      chk("tmo_err_pulses", ierr_cnt - base, 1);
      chk("tmo_i_dtr", i_dtr, 32'h5555AAAA);
      delay_cfg = 3; rd_fixed_val = 32'h13579BDF;
      req(1, 1'b0, 32'h00000304, 32'h0);
      repeat (10) step();
      chk("tmo_next_dtr", i_dtr, 32'h13579BDF);

      // strobe while busy is dropped
      delay_cfg = 6;
      base = dack_cnt;
      req(0, 1'b0, 32'h00000080, 32'h0);
      repeat (3) step();
      req(0, 1'b0, 32'h00000040, 32'h0);
      repeat (12) step();
      chk("busy_one_ack", dack_cnt - base, 1);

      // starvation protection
      grants.delete();
      delay_cfg = 2; auto_d = 1; auto_i = 1;
      req(0, 1'b0, 32'h00000100, 32'h0);
      req(1, 1'b0, 32'h00000200, 32'h0);
      for (int k = 0; k < 200 && grants.size() < 10; k++) step();
      auto_d = 0; auto_i = 0;
      repeat (30) step();
      for (int j = 0; j < 10; j++)
         chk($sformatf("starve_grant%0d", j), j < grants.size() ? grants[j] : 9, exp_g[j]);

      // asynchronous reset in the middle of WAIT
      delay_cfg = 7;
      req(0, 1'b0, 32'h00000500, 32'h0);
      repeat (4) step();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_m_stb", m_stb, 1'b0);
      chk("arst_d_ack", d_ack, 1'b0);
      chk("arst_d_busy", d_busy, 1'b0);
      model_reset();
      repeat (2) step();
      reset = 1'b0;
      delay_cfg = 3; rd_fixed_val = 32'h2468ACE0;
      req(0, 1'b0, 32'h00000600, 32'h0);
      repeat (10) step();
      chk("arst_next_dtr", d_dtr, 32'h2468ACE0);

      // randomized traffic with stray acks and occasional timeouts
      rd_fixed = 1'b0; delay_rand = 1; stray_en = 1;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 3) == 0) req(0, 1'($urandom), $urandom, $urandom);
         if ($urandom_range(0, 4) == 0) req(1, 1'($urandom), $urandom, $urandom);
         step();
      end
      repeat (60) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
